// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/subtract unit.
//   state_t     : controller states (IDLE, RUN, DONE)
//   ADD / SUB   : encodings of the add_sub operation select
//   calc_nchunk : number of CHUNK_W-wide slices in a DATA_W operand
//   calc_cnt_w  : chunk counter width, never less than one bit
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

  function automatic int calc_nchunk(input int data_w, input int chunk_w);
    return (chunk_w < 1) ? 1 : data_w / chunk_w;
  endfunction

  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice with carry in/out. The serial unit reuses
// a single instance every cycle, feeding it one operand slice at a time.
//   a, b : operand slices
//   cin  : carry from the previous slice
//   sum  : slice sum
//   cout : carry out of the slice MSB
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract unit, CHUNK_W bits per clock, LSB chunk first.
//   clk, reset      : clock and asynchronous active-high reset
//   start           : request, accepted in IDLE or DONE
//   dataa, datab    : operands, captured on the accept edge
//   add_sub         : 1 = A+B, 0 = A-B, captured on the accept edge
//   busy            : high while chunks are being summed
//   done            : one-cycle pulse when result/flags update
//   result          : sum or difference (modulo 2^DATA_W)
//   carry           : carry out of MSB (for subtract, 1 = no borrow)
//   overflow        : two's-complement signed overflow
//   zero, negative  : result == 0, result MSB
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  input  logic              add_sub,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              overflow,
  output logic              zero,
  output logic              negative
);

  localparam int NCHUNK = calc_nchunk(DATA_W, CHUNK_W);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK_W < 1) begin : g_bad_chunk
      $error("addsub_serial: CHUNK_W must be at least 1");
    end else if ((DATA_W % CHUNK_W) != 0) begin : g_bad_width
      $error("addsub_serial: DATA_W must be a multiple of CHUNK_W");
    end
  endgenerate

  state_t            state;
  logic [DATA_W-1:0] a_sr;
  logic [DATA_W-1:0] b_sr;
  logic [DATA_W-1:0] b_in;
  logic              c;
  logic              a_msb;
  logic              b_msb;
  logic [CNT_W-1:0]  count;
  logic [CHUNK_W-1:0] chunk_sum;
  logic              chunk_cout;
  logic [DATA_W-1:0] sum_next;

  // Subtraction is A + ~B + 1; the +1 comes from the initial carry.
  assign b_in = add_sub ? datab : ~datab;

  // Operand registers shift right each cycle, so the adder always sees the
  // current chunk in the low CHUNK_W bits.
  addsub_chunk #(.W(CHUNK_W)) u_chunk (
    .a    (a_sr[CHUNK_W-1:0]),
    .b    (b_sr[CHUNK_W-1:0]),
    .cin  (c),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Completed chunks collect in a private accumulator that never drives
  // result, so partial sums stay invisible. On the final cycle the current
  // chunk sum becomes the top slice of the full-width value.
  generate
    if (NCHUNK == 1) begin : g_single
      assign sum_next = chunk_sum;
    end else begin : g_multi
      logic [DATA_W-CHUNK_W-1:0] acc;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc <= '0;
        end else if (state == RUN) begin
          acc <= sum_next[DATA_W-1:CHUNK_W];
        end
      end

      assign sum_next = {chunk_sum, acc};
    end
  endgenerate

  // Controller: IDLE/DONE accept a start, RUN consumes one chunk per edge and
  // publishes result and flags on the edge it leaves for DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      c        <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= dataa;
            b_sr  <= b_in;
            a_msb <= dataa[DATA_W-1];
            b_msb <= b_in[DATA_W-1];
            c     <= ~add_sub;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> CHUNK_W;
          b_sr  <= b_sr >> CHUNK_W;
          c     <= chunk_cout;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= sum_next;
            carry    <= chunk_cout;
            overflow <= (a_msb == b_msb) && (sum_next[DATA_W-1] != a_msb);
            zero     <= (sum_next == '0);
            negative <= sum_next[DATA_W-1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: a 16/4 instance exercised through a
// scoreboard, plus a 16/16 single-cycle instance for the degenerate build.
module tb_addsub_serial;
  import addsub_pkg::*;

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] lit;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        start, add_sub;
  logic [15:0] dataa, datab;
  logic        busy, done, carry, overflow, zero, negative;
  logic [15:0] result;

  logic        start_w, add_sub_w;
  logic [15:0] dataa_w, datab_w;
  logic        busy_w, done_w, carry_w, overflow_w, zero_w, negative_w;
  logic [15:0] result_w;

  exp_t sb[$];
  exp_t sb_w[$];

  int vectors_applied = 0;
  int miscompares     = 0;
  int done_count      = 0;
  int cycle_count     = 0;

  addsub_serial #(.DATA_W(16), .CHUNK_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dataa    (dataa),
    .datab    (datab),
    .add_sub  (add_sub),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  addsub_serial #(.DATA_W(16), .CHUNK_W(16)) dut_w (
    .clk      (clk),
    .reset    (reset),
    .start    (start_w),
    .dataa    (dataa_w),
    .datab    (datab_w),
    .add_sub  (add_sub_w),
    .busy     (busy_w),
    .done     (done_w),
    .result   (result_w),
    .carry    (carry_w),
    .overflow (overflow_w),
    .zero     (zero_w),
    .negative (negative_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count++;

  // Reference arithmetic done on plain integers: unsigned compare for the
  // borrow, signed range test for overflow.
  function automatic exp_t calcExpected(input logic [15:0] a, input logic [15:0] b,
                                        input logic op);
    exp_t        e;
    logic [16:0] u;
    int          sa, sbv, s;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (op) begin
      u        = {1'b0, a} + {1'b0, b};
      e.result = u[15:0];
      e.carry  = u[16];
      s        = sa + sbv;
    end else begin
      e.result = a - b;
      e.carry  = (a >= b);
      s        = sa - sbv;
    end
    e.overflow = (s > 32767) || (s < -32768);
    e.zero     = (e.result == 16'h0000);
    e.negative = e.result[15];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Caller guarantees the DUT is idle; the start is accepted on the next edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic op);
    dataa   = a;
    datab   = b;
    add_sub = op;
    start   = 1'b1;
    sb.push_back(calcExpected(a, b, op));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : sb_monitor
    exp_t e;
    if (!reset && done) begin
      done_count++;
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_result",   32'(result),   32'(e.result));
        checkOutput("sb_carry",    32'(carry),    32'(e.carry));
        checkOutput("sb_overflow", 32'(overflow), 32'(e.overflow));
        checkOutput("sb_zero",     32'(zero),     32'(e.zero));
        checkOutput("sb_negative", 32'(negative), 32'(e.negative));
      end
    end
  end

  always @(negedge clk) begin : sb_w_monitor
    exp_t e;
    if (!reset && done_w) begin
      if (sb_w.size() == 0) begin
        checkOutput("w_spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_w.pop_front();
        checkOutput("w_sb_result",   32'(result_w),   32'(e.result));
        checkOutput("w_sb_carry",    32'(carry_w),    32'(e.carry));
        checkOutput("w_sb_overflow", 32'(overflow_w), 32'(e.overflow));
        checkOutput("w_sb_zero",     32'(zero_w),     32'(e.zero));
        checkOutput("w_sb_negative", 32'(negative_w), 32'(e.negative));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors_applied);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t        vecs[7];
    int          dc;
    int          done_cyc[3];
    bit          seen;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h0006, 16'h0002, SUB, 16'h0004};
    vecs[1] = '{16'h0002, 16'h0006, SUB, 16'hFFFC};
    vecs[2] = '{16'h7FFF, 16'h0001, ADD, 16'h8000};
    vecs[3] = '{16'hFFFF, 16'h0001, ADD, 16'h0000};
    vecs[4] = '{16'h8000, 16'h0001, SUB, 16'h7FFF};
    vecs[5] = '{16'h0000, 16'h0000, SUB, 16'h0000};
    vecs[6] = '{16'h1234, 16'h1234, SUB, 16'h0000};

    reset = 1'b1;
    start = 1'b0; dataa = '0; datab = '0; add_sub = 1'b0;
    start_w = 1'b0; dataa_w = '0; datab_w = '0; add_sub_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",   32'(busy),   32'd0);
    checkOutput("rst_done",   32'(done),   32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carry",  32'(carry),  32'd0);
    checkOutput("rst_zero",   32'(zero),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Handshake timing: four busy cycles, done on the fifth.
    applyStimulus(16'd6, 16'd2, ADD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t1_busy",    32'(busy), 32'd1);
      checkOutput("t1_no_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("t1_done",       32'(done),   32'd1);
    checkOutput("t1_busy_low",   32'(busy),   32'd0);
    checkOutput("t1_result_lit", 32'(result), 32'd8);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t1_done_pulse", 32'(done), 32'd0);

    // Directed boundary cases, each also checked against a literal result.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].a, vecs[k].b, vecs[k].op);
      waitDone("op_done_seen", 12);
      checkOutput("op_result_lit", 32'(result), 32'(vecs[k].lit));
    end

    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb, k[0]);
      waitDone("rand_done_seen", 12);
    end

    // A start while busy must be dropped, not queued.
    applyStimulus(16'h1234, 16'h0F0F, ADD);
    @(posedge clk);
    #1;
    dataa = 16'hAAAA; datab = 16'h5555; add_sub = SUB; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ign_done_seen", 12);
    checkOutput("ign_result_lit", 32'(result), 32'h2143);
    dc = done_count;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("ign_no_extra_done", 32'(done_count), 32'(dc));

    // start held high: back-to-back operations, one done every five cycles.
    dataa = 16'h0100; datab = 16'h0011; add_sub = ADD; start = 1'b1;
    sb.push_back(calcExpected(dataa, datab, add_sub));
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      checkOutput("held_done_seen", 32'(seen), 32'd1);
      done_cyc[k] = cycle_count;
      if (k < 2) begin
        dataa   = dataa + 16'h0111;
        datab   = datab + 16'h0011;
        add_sub = ~add_sub;
        sb.push_back(calcExpected(dataa, datab, add_sub));
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("held_period_a", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
    checkOutput("held_period_b", 32'(done_cyc[2] - done_cyc[1]), 32'd5);
    @(posedge clk);
    #1;

    // Reset in the second RUN cycle discards the operation.
    applyStimulus(16'h0F0F, 16'h0101, ADD);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rmid_busy",     32'(busy),     32'd0);
    checkOutput("rmid_done",     32'(done),     32'd0);
    checkOutput("rmid_result",   32'(result),   32'd0);
    checkOutput("rmid_carry",    32'(carry),    32'd0);
    checkOutput("rmid_overflow", 32'(overflow), 32'd0);
    checkOutput("rmid_negative", 32'(negative), 32'd0);
    sb.delete();
    dc = done_count;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rmid_no_done", 32'(done_count), 32'(dc));
    applyStimulus(16'h0F0F, 16'h0101, ADD);
    waitDone("rmid_new_done_seen", 12);
    checkOutput("rmid_new_result_lit", 32'(result), 32'h1010);

    // Single-chunk build: done in the cycle after the first RUN edge.
    dataa_w = 16'h8000; datab_w = 16'h0001; add_sub_w = SUB; start_w = 1'b1;
    sb_w.push_back(calcExpected(dataa_w, datab_w, add_sub_w));
    @(posedge clk);
    #1;
    start_w = 1'b0;
    @(negedge clk);
    checkOutput("w_busy",    32'(busy_w), 32'd1);
    checkOutput("w_no_done", 32'(done_w), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("w_done",       32'(done_w),     32'd1);
    checkOutput("w_result_lit", 32'(result_w),   32'h7FFF);
    checkOutput("w_ovf_lit",    32'(overflow_w), 32'd1);
    @(posedge clk);
    #1;

    checkOutput("sb_drained",   32'(sb.size()),   32'd0);
    checkOutput("sb_w_drained", 32'(sb_w.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
